reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter TAG_W, default 3, ROB tag width (8-entry ROB).
REQ-002 Parameter XLEN, default 32, operand/data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 load_i  input  1  allocate strobe from issue queue (resN_load).
REQ-006 ctl_i  input  tomasula_types::ctl_word  op, src1/src2 reg+valid, src2_data, funct3, funct7, rd, pc.
REQ-007 rob_tag_i  input  TAG_W  destination ROB tag assigned this cycle.
REQ-008 src1_rdy_i / src2_rdy_i  input  1 each  register-file/ROB value already available.
REQ-009 src1_data_i / src2_data_i  input  XLEN each  available operand value.
REQ-010 src1_tag_i / src2_tag_i  input  TAG_W each  producing ROB tag when not ready.
REQ-011 cdb_valid_i  input  1  common data bus broadcast valid.
REQ-012 cdb_tag_i  input  TAG_W  broadcast ROB tag.
REQ-013 cdb_data_i  input  XLEN  broadcast result.
REQ-014 flush_i  input  1  synchronous squash from ROB (mispredict).
REQ-015 empty_o  output  1  station free; drives issue queue resN_empty.
REQ-016 exec_valid_o  output  1  operands complete, request to functional unit.
REQ-017 exec_ready_i  input  1  functional unit accepts this cycle.
REQ-018 exec_op_o, exec_funct3_o, exec_funct7_o  output  per ctl_word  latched decode fields.
REQ-019 exec_a_o / exec_b_o  output  XLEN each  operands A/B.
REQ-020 exec_tag_o  output  TAG_W  destination ROB tag.
REQ-021 exec_pc_o  output  XLEN  latched pc.

Function
REQ-022 Single entry; state machine EMPTY, WAIT, READY; empty_o = (state==EMPTY), registered.
REQ-023 EMPTY + load_i: latch ctl_i fields and rob_tag_i; next state READY if both operands resolved at that edge, else WAIT.
REQ-024 Operand A resolution at load: src1_valid=0 -> A=ctl_i.pc, ready; src1_rdy_i=1 -> A=src1_data_i; else cdb_valid_i & cdb_tag_i==src1_tag_i -> A=cdb_data_i; else store src1_tag_i, pending.
REQ-025 Operand B resolution at load: src2_valid=0 -> B=ctl_i.src2_data (immediate), ready; otherwise identical to REQ-024 using src2 inputs.
REQ-026 WAIT: each cycle, each pending operand whose stored tag equals cdb_tag_i with cdb_valid_i captures cdb_data_i; both operands may capture from one broadcast.
REQ-027 WAIT -> READY at the edge where the last pending operand captures; latency CDB broadcast -> exec_valid_o = 1 cycle.
REQ-028 exec_valid_o = (state==READY); exec_* outputs hold stable while exec_valid_o=1 and exec_ready_i=0.
REQ-029 READY with exec_valid_o & exec_ready_i -> EMPTY at that edge; empty_o=1 next cycle.
REQ-030 load_i while state != EMPTY is ignored; no field, tag or state change.
REQ-031 Load with both operands ready -> exec_valid_o=1 on the following cycle; minimum station occupancy 2 cycles.
REQ-032 flush_i=1 -> state EMPTY at next edge, overriding load_i, CDB capture and handshake in that cycle.
REQ-033 CDB broadcast with non-matching tag or cdb_valid_i=0 changes nothing.
REQ-034 Tags compared over full TAG_W; no wrap-around handling beyond equality.

Reset
REQ-035 rst=0 asynchronously forces state EMPTY: empty_o=1, exec_valid_o=0, all latched fields, operands and tags to 0.
REQ-036 rst asserted mid-WAIT or mid-READY discards the entry; first load after rst deassertion is accepted normally.

Verification
REQ-037 Load add, src1_rdy=1 data 0x5, src2_valid=0 imm 0x7, tag 2 -> next cycle exec_valid_o=1, A=0x5, B=0x7, exec_tag_o=2, empty_o=0.
REQ-038 Load, src1 pending tag 4, src2 pending tag 6; CDB tag 6 data 0x10, then tag 4 data 0x20 -> exec_valid_o=1 one cycle after second broadcast, A=0x20, B=0x10.
REQ-039 Load, both pending tag 3, CDB tag 3 data 0xAB in the load cycle -> READY next cycle, A=B=0xAB.
REQ-040 READY with exec_ready_i=0 for 3 cycles, then 1 -> outputs constant 3 cycles, empty_o=1 cycle after accept; second load_i during hold ignored.
REQ-041 WAIT entry, flush_i=1 same cycle as matching CDB -> empty_o=1 next cycle, exec_valid_o never asserted.
REQ-042 rst pulsed low mid-WAIT -> immediately empty_o=1, exec_valid_o=0; new load after release produces correct operands.

Source files
------------

// File: rtl/reservation_station.sv
// Single-entry reservation station: captures an issued instruction, resolves
// its two operands from the register file or the common data bus, and
// presents the complete operation to a functional unit with a valid/ready
// handshake.

package tomasula_types;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned WORD_W = 32;

    // Decoded instruction as delivered by the issue queue
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  src1_reg;
        logic              src1_valid;
        logic [REG_W-1:0]  src2_reg;
        logic              src2_valid;
        logic [WORD_W-1:0] src2_data;
        logic [F3_W-1:0]   funct3;
        logic [F7_W-1:0]   funct7;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] pc;
    } ctl_word;

endpackage

module reservation_station #(
    parameter int unsigned TAG_W = 3,
    parameter int unsigned XLEN  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_i,
    input  tomasula_types::ctl_word         ctl_i,
    input  logic [TAG_W-1:0]                rob_tag_i,
    input  logic                            src1_rdy_i,
    input  logic                            src2_rdy_i,
    input  logic [XLEN-1:0]                 src1_data_i,
    input  logic [XLEN-1:0]                 src2_data_i,
    input  logic [TAG_W-1:0]                src1_tag_i,
    input  logic [TAG_W-1:0]                src2_tag_i,
    input  logic                            cdb_valid_i,
    input  logic [TAG_W-1:0]                cdb_tag_i,
    input  logic [XLEN-1:0]                 cdb_data_i,
    input  logic                            flush_i,
    output logic                            empty_o,
    output logic                            exec_valid_o,
    input  logic                            exec_ready_i,
    output logic [tomasula_types::OP_W-1:0] exec_op_o,
    output logic [tomasula_types::F3_W-1:0] exec_funct3_o,
    output logic [tomasula_types::F7_W-1:0] exec_funct7_o,
    output logic [XLEN-1:0]                 exec_a_o,
    output logic [XLEN-1:0]                 exec_b_o,
    output logic [TAG_W-1:0]                exec_tag_o,
    output logic [XLEN-1:0]                 exec_pc_o
);

    import tomasula_types::*;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [F7_W-1:0]   funct7_q, funct7_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              a_pend_q, a_pend_d;
    logic              b_pend_q, b_pend_d;
    logic [TAG_W-1:0]  a_tag_q, a_tag_d;
    logic [TAG_W-1:0]  b_tag_q, b_tag_d;
    logic              empty_q;
    logic              valid_q;

    // Register indices and rd are tracked by the ROB, not needed here
    logic unused_ctl_bits;
    assign unused_ctl_bits = ^{ctl_i.src1_reg, ctl_i.src2_reg, ctl_i.rd};

    // Next-state, operand resolution and CDB capture
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        tag_d    = tag_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        a_pend_d = a_pend_q;
        b_pend_d = b_pend_q;
        a_tag_d  = a_tag_q;
        b_tag_d  = b_tag_q;

        if (flush_i) begin
            // Squash wins over every other event this cycle
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (load_i) begin
                        op_d     = ctl_i.op;
                        funct3_d = ctl_i.funct3;
                        funct7_d = ctl_i.funct7;
                        tag_d    = rob_tag_i;
                        pc_d     = XLEN'(ctl_i.pc);

                        // Operand A: pc when unused, else regfile, else same-cycle CDB
                        a_pend_d = 1'b0;
                        a_tag_d  = '0;
                        if (!ctl_i.src1_valid) begin
                            a_d = XLEN'(ctl_i.pc);
                        end else if (src1_rdy_i) begin
                            a_d = src1_data_i;
                        end else if (cdb_valid_i && (cdb_tag_i == src1_tag_i)) begin
                            a_d = cdb_data_i;
                        end else begin
                            a_d      = '0;
                            a_pend_d = 1'b1;
                            a_tag_d  = src1_tag_i;
                        end

                        // Operand B: immediate when unused, otherwise as operand A
                        b_pend_d = 1'b0;
                        b_tag_d  = '0;
                        if (!ctl_i.src2_valid) begin
                            b_d = XLEN'(ctl_i.src2_data);
                        end else if (src2_rdy_i) begin
                            b_d = src2_data_i;
                        end else if (cdb_valid_i && (cdb_tag_i == src2_tag_i)) begin
                            b_d = cdb_data_i;
                        end else begin
                            b_d      = '0;
                            b_pend_d = 1'b1;
                            b_tag_d  = src2_tag_i;
                        end

                        state_d = (a_pend_d || b_pend_d) ? ST_WAIT : ST_READY;
                    end
                end

                ST_WAIT: begin
                    // One broadcast may satisfy both operands
                    if (cdb_valid_i) begin
                        if (a_pend_q && (cdb_tag_i == a_tag_q)) begin
                            a_d      = cdb_data_i;
                            a_pend_d = 1'b0;
                        end
                        if (b_pend_q && (cdb_tag_i == b_tag_q)) begin
                            b_d      = cdb_data_i;
                            b_pend_d = 1'b0;
                        end
                    end
                    if (!a_pend_d && !b_pend_d) begin
                        state_d = ST_READY;
                    end
                end

                ST_READY: begin
                    if (exec_ready_i) begin
                        state_d = ST_EMPTY;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, entry payload and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            op_q     <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            tag_q    <= '0;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
            a_tag_q  <= '0;
            b_tag_q  <= '0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            tag_q    <= tag_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
            a_tag_q  <= a_tag_d;
            b_tag_q  <= b_tag_d;
            empty_q  <= (state_d == ST_EMPTY);
            valid_q  <= (state_d == ST_READY);
        end
    end

    assign empty_o       = empty_q;
    assign exec_valid_o  = valid_q;
    assign exec_op_o     = op_q;
    assign exec_funct3_o = funct3_q;
    assign exec_funct7_o = funct7_q;
    assign exec_a_o      = a_q;
    assign exec_b_o      = b_q;
    assign exec_tag_o    = tag_q;
    assign exec_pc_o     = pc_q;

endmodule

// File: tb/tb_reservation_station.sv
// Randomized scoreboard bench for the single-entry reservation station.
module tb_reservation_station;

    import tomasula_types::*;

    localparam int unsigned TAG_W = 3;
    localparam int unsigned XLEN  = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [F3_W-1:0]  f3;
        logic [F7_W-1:0]  f7;
        word_t            a;
        word_t            b;
        logic [TAG_W-1:0] tag;
        word_t            pc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             load_i;
    ctl_word          ctl_i;
    logic [TAG_W-1:0] rob_tag_i;
    logic             src1_rdy_i, src2_rdy_i;
    word_t            src1_data_i, src2_data_i;
    logic [TAG_W-1:0] src1_tag_i, src2_tag_i;
    logic             cdb_valid_i;
    logic [TAG_W-1:0] cdb_tag_i;
    word_t            cdb_data_i;
    logic             flush_i;
    logic             empty_o;
    logic             exec_valid_o;
    logic             exec_ready_i;
    logic [OP_W-1:0]  exec_op_o;
    logic [F3_W-1:0]  exec_funct3_o;
    logic [F7_W-1:0]  exec_funct7_o;
    word_t            exec_a_o, exec_b_o, exec_pc_o;
    logic [TAG_W-1:0] exec_tag_o;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    reservation_station #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .ctl_i(ctl_i), .rob_tag_i(rob_tag_i),
        .src1_rdy_i(src1_rdy_i), .src2_rdy_i(src2_rdy_i),
        .src1_data_i(src1_data_i), .src2_data_i(src2_data_i),
        .src1_tag_i(src1_tag_i), .src2_tag_i(src2_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .flush_i(flush_i), .empty_o(empty_o), .exec_valid_o(exec_valid_o),
        .exec_ready_i(exec_ready_i), .exec_op_o(exec_op_o),
        .exec_funct3_o(exec_funct3_o), .exec_funct7_o(exec_funct7_o),
        .exec_a_o(exec_a_o), .exec_b_o(exec_b_o), .exec_tag_o(exec_tag_o),
        .exec_pc_o(exec_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever an operation is presented it must match the oldest expectation
    always @(negedge clk) begin
        if (rst && exec_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_unexpected: got exec_valid_o=1 expected no outstanding op at %0t", $time);
            end else begin
                mon_e = sb[0];
                chk("exec_op",  64'(exec_op_o),     64'(mon_e.op));
                chk("exec_f3",  64'(exec_funct3_o), 64'(mon_e.f3));
                chk("exec_f7",  64'(exec_funct7_o), 64'(mon_e.f7));
                chk("exec_a",   64'(exec_a_o),      64'(mon_e.a));
                chk("exec_b",   64'(exec_b_o),      64'(mon_e.b));
                chk("exec_tag", 64'(exec_tag_o),    64'(mon_e.tag));
                chk("exec_pc",  64'(exec_pc_o),     64'(mon_e.pc));
                if (exec_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_word rand_ctl();
        ctl_word c;
        c.op         = OP_W'($urandom);
        c.src1_reg   = REG_W'($urandom);
        c.src1_valid = 1'($urandom);
        c.src2_reg   = REG_W'($urandom);
        c.src2_valid = 1'($urandom);
        c.src2_data  = WORD_W'($urandom);
        c.funct3     = F3_W'($urandom);
        c.funct7     = F7_W'($urandom);
        c.rd         = REG_W'($urandom);
        c.pc         = WORD_W'($urandom);
        return c;
    endfunction

    // Quiet control inputs, random data inputs
    task automatic idle_inputs();
        load_i       = 1'b0;
        cdb_valid_i  = 1'b0;
        flush_i      = 1'b0;
        exec_ready_i = 1'b0;
        ctl_i        = rand_ctl();
        rob_tag_i    = TAG_W'($urandom);
        src1_rdy_i   = 1'($urandom);
        src2_rdy_i   = 1'($urandom);
        src1_data_i  = word_t'($urandom);
        src2_data_i  = word_t'($urandom);
        src1_tag_i   = TAG_W'($urandom);
        src2_tag_i   = TAG_W'($urandom);
        cdb_tag_i    = TAG_W'($urandom);
        cdb_data_i   = word_t'($urandom);
    endtask

    // Operand modes: 0 unused (pc/imm), 1 ready, 2 CDB in load cycle, 3 pending
    // abort: 0 none, 1 flush in WAIT with matching CDB, 2 flush in READY, 3 reset after load
    task automatic run_txn(input int ma, input int mb, input logic [TAG_W-1:0] rtag,
                           input logic [TAG_W-1:0] ta_in, input logic [TAG_W-1:0] tb_in,
                           input word_t va_in, input word_t vb_in, input bit b_first,
                           input int hold, input int abort);
        ctl_word          c;
        exp_t             e;
        logic [TAG_W-1:0] ta, tb, lt, nt;
        word_t            va, vb, ld;
        logic             lcdb;
        int               npend;
        logic [TAG_W-1:0] ptag [2];
        word_t            pdat [2];

        ta = ta_in; tb = tb_in; va = va_in; vb = vb_in;
        c  = rand_ctl();
        c.src1_valid = (ma != 0);
        c.src2_valid = (mb != 0);
        if (ma == 2 && mb == 2) begin tb = ta; vb = va; end
        lcdb = (ma == 2) || (mb == 2);
        lt   = (ma == 2) ? ta : tb;
        ld   = (ma == 2) ? va : vb;
        if (lcdb) begin
            if (ma == 3 && ta == lt) ta = lt + 1'b1;
            if (mb == 3 && tb == lt) tb = lt + 1'b1;
        end
        if (ma == 3 && mb == 3 && ta == tb) vb = va;
        if (!lcdb && $urandom_range(0, 1) == 1) begin
            // Non-matching broadcast during the load must be ignored
            lcdb = 1'b1;
            ld   = word_t'($urandom);
            do lt = TAG_W'($urandom); while ((ma == 3 && lt == ta) || (mb == 3 && lt == tb));
        end
        if (mb == 0) c.src2_data = WORD_W'(vb);

        e.op  = c.op;
        e.f3  = c.funct3;
        e.f7  = c.funct7;
        e.tag = rtag;
        e.pc  = word_t'(c.pc);
        e.a   = (ma == 0) ? word_t'(c.pc) : va;
        e.b   = vb;
        sb.push_back(e);

        load_i       = 1'b1;
        ctl_i        = c;
        rob_tag_i    = rtag;
        src1_rdy_i   = (ma == 1) ? 1'b1 : ((ma == 0) ? 1'($urandom) : 1'b0);
        src2_rdy_i   = (mb == 1) ? 1'b1 : ((mb == 0) ? 1'($urandom) : 1'b0);
        src1_data_i  = (ma == 1) ? va : word_t'($urandom);
        src2_data_i  = (mb == 1) ? vb : word_t'($urandom);
        src1_tag_i   = (ma >= 2) ? ta : TAG_W'($urandom);
        src2_tag_i   = (mb >= 2) ? tb : TAG_W'($urandom);
        cdb_valid_i  = lcdb;
        cdb_tag_i    = lt;
        cdb_data_i   = ld;
        exec_ready_i = 1'($urandom);
        flush_i      = 1'b0;
        step();
        idle_inputs();

        npend = 0;
        if (ma == 3) begin ptag[npend] = ta; pdat[npend] = va; npend++; end
        if (mb == 3 && !(ma == 3 && tb == ta)) begin ptag[npend] = tb; pdat[npend] = vb; npend++; end
        if (b_first && npend == 2) begin
            ptag[0] = tb; pdat[0] = vb; ptag[1] = ta; pdat[1] = va;
        end

        if (abort == 3) begin
            rst = 1'b0;
            #1;
            chk("rst_empty", 64'(empty_o), 64'd1);
            chk("rst_valid", 64'(exec_valid_o), 64'd0);
            chk("rst_a",     64'(exec_a_o), 64'd0);
            chk("rst_b",     64'(exec_b_o), 64'd0);
            chk("rst_tag",   64'(exec_tag_o), 64'd0);
            chk("rst_op",    64'(exec_op_o), 64'd0);
            chk("rst_pc",    64'(exec_pc_o), 64'd0);
            #1;
            rst = 1'b1;
            void'(sb.pop_front());
            return;
        end

        for (int i = 0; i < npend; i++) begin
            chk("wait_valid", 64'(exec_valid_o), 64'd0);
            chk("wait_empty", 64'(empty_o), 64'd0);
            repeat ($urandom_range(0, 2)) begin
                load_i       = 1'b1;
                exec_ready_i = 1'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    cdb_valid_i = 1'b0;
                    cdb_tag_i   = ptag[i];
                end else begin
                    cdb_valid_i = 1'b1;
                    do nt = TAG_W'($urandom);
                    while (nt == ptag[i] || (npend == 2 && i == 0 && nt == ptag[1]));
                    cdb_tag_i = nt;
                end
                step();
                idle_inputs();
                chk("noise_valid", 64'(exec_valid_o), 64'd0);
                chk("noise_empty", 64'(empty_o), 64'd0);
            end
            if (abort == 1) begin
                cdb_valid_i = 1'b1;
                cdb_tag_i   = ptag[i];
                flush_i     = 1'b1;
                step();
                idle_inputs();
                chk("flushw_empty", 64'(empty_o), 64'd1);
                chk("flushw_valid", 64'(exec_valid_o), 64'd0);
                void'(sb.pop_front());
                step();
                chk("flushw_valid2", 64'(exec_valid_o), 64'd0);
                return;
            end
            cdb_valid_i = 1'b1;
            cdb_tag_i   = ptag[i];
            cdb_data_i  = pdat[i];
            step();
            idle_inputs();
        end

        chk("ready_valid", 64'(exec_valid_o), 64'd1);
        chk("ready_empty", 64'(empty_o), 64'd0);
        for (int h = 0; h < hold; h++) begin
            load_i      = 1'b1;
            cdb_valid_i = 1'($urandom);
            step();
            idle_inputs();
            chk("hold_valid", 64'(exec_valid_o), 64'd1);
            chk("hold_empty", 64'(empty_o), 64'd0);
        end

        if (abort == 2) begin
            flush_i = 1'b1;
            step();
            idle_inputs();
            chk("flushr_empty", 64'(empty_o), 64'd1);
            chk("flushr_valid", 64'(exec_valid_o), 64'd0);
            void'(sb.pop_front());
            return;
        end

        exec_ready_i = 1'b1;
        step();
        idle_inputs();
        chk("accept_empty", 64'(empty_o), 64'd1);
        chk("accept_valid", 64'(exec_valid_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", 64'(empty_o), 64'd1);
        chk("reset_valid", 64'(exec_valid_o), 64'd0);
        chk("reset_a",     64'(exec_a_o), 64'd0);
        chk("reset_tag",   64'(exec_tag_o), 64'd0);
        rst = 1'b1;
        step();

        // Ready source plus immediate
        run_txn(1, 0, 3'd2, 3'd0, 3'd0, 32'h5, 32'h7, 1'b0, 0, 0);
        // Two pending tags, B's producer broadcasts first
        run_txn(3, 3, 3'd1, 3'd4, 3'd6, 32'h20, 32'h10, 1'b1, 0, 0);
        // Both operands caught by a broadcast in the load cycle
        run_txn(2, 2, 3'd5, 3'd3, 3'd3, 32'hAB, 32'hAB, 1'b0, 0, 0);
        // Three-cycle backpressure with ignored loads
        run_txn(1, 1, 3'd7, 3'd0, 3'd0, 32'h1111, 32'h2222, 1'b0, 3, 0);
        // Flush alongside a matching broadcast
        run_txn(3, 1, 3'd0, 3'd5, 3'd0, 32'h33, 32'h44, 1'b0, 0, 1);
        // Reset mid-wait, then a normal load
        run_txn(3, 3, 3'd4, 3'd1, 3'd2, 32'h55, 32'h66, 1'b0, 0, 3);
        run_txn(3, 0, 3'd6, 3'd2, 3'd0, 32'h77, 32'h88, 1'b0, 1, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), TAG_W'($urandom),
                    TAG_W'($urandom), TAG_W'($urandom), word_t'($urandom), word_t'($urandom),
                    1'($urandom), $urandom_range(0, 3),
                    (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0);
        end

        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
